// File: rtl/wide_add_seq.sv
// Multi-word add/subtract sequencer around an external 32-bit combinational adder.
// Optional running-accumulator mode when WIDE_ADD_SEQ_ACC_EN is defined.

module wide_add_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WORDS-1:0]   op_a,
  input  logic [32*WORDS-1:0]   op_b,
  input  logic                  op_sub,
`ifdef WIDE_ADD_SEQ_ACC_EN
  input  logic                  acc_mode,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_cin,
  input  logic [31:0]           add_sum,
  input  logic                  add_cout
);

  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e                      state_q, state_d;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic                        cy_q, cy_d;
  logic [WORDS-1:0][31:0]      a_q, a_d;
  logic [WORDS-1:0][31:0]      b_q, b_d;
  logic [WORDS-1:0][31:0]      res_q, res_d;
  logic                        carry_q, carry_d;
  logic                        ovf_q, ovf_d;
  logic [WORDS-1:0][31:0]      a_src;

  // In accumulate mode the held result becomes the next A operand.
`ifdef WIDE_ADD_SEQ_ACC_EN
  assign a_src = acc_mode ? res_q : op_a;
`else
  assign a_src = op_a;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cy_d      = cy_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 32'h0;
    add_b     = 32'h0;
    add_cin   = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a_src;
          b_d     = op_sub ? ~op_b : op_b;
          cy_d    = op_sub;
          idx_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        add_a        = a_q[idx_q];
        add_b        = b_q[idx_q];
        add_cin      = cy_q;
        res_d[idx_q] = add_sum;
        cy_d         = add_cout;
        idx_d        = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          carry_d = add_cout;
          // Operands share a sign but the top word's sum flipped it.
          ovf_d   = (a_q[WORDS-1][31] == b_q[WORDS-1][31]) &&
                    (add_sum[31] != a_q[WORDS-1][31]);
          idx_d   = '0;
          state_d = StDone;
        end
      end

      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign result    = res_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq: directed and random add/sub operations checked against
// a whole-width arithmetic model; the 32-bit adder is modelled alongside.

module tb_wide_add_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 32 * WORDS;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          op_sub;
  logic          acc_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          carry_out;
  logic          overflow;
  logic [31:0]   add_a;
  logic [31:0]   add_b;
  logic          add_cin;
  logic [31:0]   add_sum;
  logic          add_cout;

  int            checks;
  int            failures;
  logic [W-1:0]  model_res;

  wide_add_seq #(
    .WORDS(WORDS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
`ifdef WIDE_ADD_SEQ_ACC_EN
    .acc_mode  (acc_mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  // External 32-bit adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'h0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] x;
    for (int i = 0; i < WORDS; i++) x[i*32 +: 32] = $urandom();
    return x;
  endfunction

  // Whole-width reference: unsigned result/carry, signed overflow from an extended sum.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                output logic [W-1:0] r, output logic c, output logic v);
    logic [W:0]          u;
    logic signed [W+1:0] sa, sb, s;
    sa = $signed({a[W-1], a[W-1], a});
    sb = $signed({b[W-1], b[W-1], b});
    if (sub) begin
      u = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      s = sa - sb;
    end else begin
      u = {1'b0, a} + {1'b0, b};
      s = sa + sb;
    end
    r = u[W-1:0];
    c = u[W];
    v = (s[W] != s[W-1]);
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation and wait for its result; leaves the block in DONE.
  task automatic start_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic acc);
    logic [W-1:0] ea, er;
    logic         ec, ev;
    int           n;
    ea = acc ? model_res : a;
    model(ea, b, sub, er, ec, ev);
    chk($sformatf("%s.in_ready", tag), W'(in_ready), W'(1));
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    acc_mode = acc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op_a     = rnd();
    op_b     = rnd();
    op_sub   = ~sub;
    acc_mode = 1'b0;
    n = 0;
    while (!out_valid && n < 4 * WORDS) begin
      tick();
      n++;
    end
    chk($sformatf("%s.latency", tag), W'(n), W'(WORDS));
    chk($sformatf("%s.result", tag), result, er);
    chk($sformatf("%s.carry", tag), W'(carry_out), W'(ec));
    chk($sformatf("%s.ovf", tag), W'(overflow), W'(ev));
    chk($sformatf("%s.busy", tag), W'(in_ready), W'(0));
    model_res = er;
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk($sformatf("%s.drained", tag), W'(out_valid), W'(0));
    chk($sformatf("%s.ready_again", tag), W'(in_ready), W'(1));
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic acc);
    start_op(tag, a, b, sub, acc);
    finish_op(tag);
  endtask

  initial begin
    logic [W-1:0] a, b, ones, smax, exp_b;
    logic [64:0]  low;
    checks    = 0;
    failures  = 0;
    model_res = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;
    acc_mode  = 1'b0;
    out_ready = 1'b0;
    ones      = '1;
    smax      = {1'b0, {(W-1){1'b1}}};
    tick();
    tick();
    chk("rst.in_ready", W'(in_ready), W'(1));
    chk("rst.out_valid", W'(out_valid), W'(0));
    chk("rst.result", result, '0);
    chk("rst.add_a", W'(add_a), '0);
    chk("rst.add_b", W'(add_b), '0);
    chk("rst.add_cin", W'(add_cin), '0);
    rst_n = 1'b1;
    tick();
    chk("idle.in_ready", W'(in_ready), W'(1));

    do_op("ripple", {32'h0, {(W-32){1'b1}}}, W'(1), 1'b0, 1'b0);
    do_op("wrap", ones, W'(1), 1'b0, 1'b0);
    do_op("ovf", smax, W'(1), 1'b0, 1'b0);
    do_op("sub_borrow", W'(5), W'(7), 1'b1, 1'b0);
    do_op("sub_pos", W'(7), W'(5), 1'b1, 1'b0);
    do_op("sub_zero", rnd(), '0, 1'b1, 1'b0);
    do_op("sub_min", W'(1), {1'b1, {(W-1){1'b0}}}, 1'b1, 1'b0);

    // Backpressure: hold DONE while upstream offers new work.
    start_op("bp", rnd(), rnd(), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      op_a     = rnd();
      op_b     = rnd();
      tick();
      chk($sformatf("bp%0d.result", i), result, model_res);
      chk($sformatf("bp%0d.out_valid", i), W'(out_valid), W'(1));
      chk($sformatf("bp%0d.in_ready", i), W'(in_ready), W'(0));
    end
    in_valid = 1'b0;
    finish_op("bp");

    for (int i = 0; i < 20; i++) begin
      do_op($sformatf("rnd%0d", i), rnd(), rnd(), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset while the third word is on the adder.
    a        = rnd();
    b        = rnd();
    op_a     = a;
    op_b     = b;
    op_sub   = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    exp_b = ~b;
    low   = {1'b0, a[63:0]} + {1'b0, exp_b[63:0]} + 65'd1;
    chk("mid.add_a", W'(add_a), W'(a[95:64]));
    chk("mid.add_b", W'(add_b), W'(exp_b[95:64]));
    chk("mid.add_cin", W'(add_cin), W'(low[64]));
    rst_n = 1'b0;
    #1;
    chk("mid_rst.result", result, '0);
    chk("mid_rst.out_valid", W'(out_valid), W'(0));
    chk("mid_rst.carry", W'(carry_out), W'(0));
    chk("mid_rst.ovf", W'(overflow), W'(0));
    chk("mid_rst.add_a", W'(add_a), '0);
    chk("mid_rst.add_cin", W'(add_cin), '0);
    tick();
    rst_n     = 1'b1;
    model_res = '0;
    tick();
    chk("post_rst.in_ready", W'(in_ready), W'(1));
    do_op("post_rst", rnd(), rnd(), 1'b0, 1'b0);

`ifdef WIDE_ADD_SEQ_ACC_EN
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    model_res = '0;
    tick();
    do_op("acc1", rnd(), W'(3), 1'b0, 1'b1);
    chk("acc1.val", result, W'(3));
    do_op("acc2", rnd(), W'(3), 1'b0, 1'b1);
    chk("acc2.val", result, W'(6));
    do_op("acc3", rnd(), W'(3), 1'b0, 1'b1);
    chk("acc3.val", result, W'(9));
    do_op("acc_sub", rnd(), W'(10), 1'b1, 1'b1);
    chk("acc_sub.val", result, ones);
    chk("acc_sub.carry", W'(carry_out), W'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
